// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read-port adapter with 2-entry valid/ready output buffer.
// Optional delivered-word counter enabled by defining FIFO_READER_CNT_EN.
module fifo_stream_reader #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              fifo_read,
  input  logic [DWIDTH-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data
`ifdef FIFO_READER_CNT_EN
  ,
  output logic [31:0]       word_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t              occ;
  occ_t              occ_next;
  logic              pending;
  logic [DWIDTH-1:0] buf0;
  logic [DWIDTH-1:0] buf1;
  logic              pop;
  logic              push;
  logic              push_to_buf0;
  logic [2:0]        credit;

  assign pop          = m_valid & m_ready;
  assign push         = pending;
  assign m_valid      = (occ != EMPTY);
  assign m_data       = buf0;
  assign push_to_buf0 = (occ == EMPTY) || ((occ == ONE) && pop);

  // Words held or in flight after this cycle's pop; pop implies occ>0, so never negative.
  assign credit    = {1'b0, occ} + {2'b00, pending} - {2'b00, pop};
  assign fifo_read = !rst && !fifo_empty && (credit < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      occ     <= EMPTY;
      pending <= 1'b0;
    end else begin
      occ     <= occ_next;
      pending <= fifo_read;
    end
  end

  always_comb begin
    occ_next = occ;
    case (occ)
      EMPTY: if (push) occ_next = ONE;
      ONE: begin
        if (push && !pop)      occ_next = TWO;
        else if (!push && pop) occ_next = EMPTY;
      end
      TWO: if (pop && !push) occ_next = ONE;
      default: occ_next = EMPTY;
    endcase
  end

  // Shift on pop first; a push into buf0 (EMPTY, or ONE with pop) overrides the shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      if (pop) buf0 <= buf1;
      if (push) begin
        if (push_to_buf0) buf0 <= fifo_dout;
        else              buf1 <= fifo_dout;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!((occ == TWO) && push && !pop));
    end
  end

`ifdef FIFO_READER_CNT_EN
  logic [31:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)      cnt <= 32'd0;
    else if (pop) cnt <= cnt + 32'd1;
  end

  assign word_cnt = cnt;
`endif

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side adapter for the FIFO read port: drives `read`, absorbs the FIFO's 1-cycle read latency, and presents the words as a valid/ready stream. It sits in the read clock domain, between the FIFO's read port and any consumer that needs a backpressured stream. A 2-entry output buffer sustains one word per cycle and never loses a word under backpressure.

## Interface
- `DWIDTH`, 32, data width; must match the FIFO's `DWIDTH`.
- `clk` in 1: clock. Connect to the FIFO's `clk_rd`.
- `rst` in 1: reset. Synchronous, active-high. Connect to the same source as the FIFO's `rst_rd`.
- `fifo_read` out 1: read request to the FIFO.
- `fifo_dout` in DWIDTH: FIFO read data. Valid the cycle after `fifo_read`.
- `fifo_empty` in 1: FIFO empty flag.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: consumer accepts the word.
- `m_data` out DWIDTH: output word.
- `word_cnt` out 32: delivered-word count. Present only with `FIFO_READER_CNT_EN`.

## Operation
- Internal state:
  - `buf0` and `buf1`, DWIDTH each. `buf0` is the head.
  - `occ`, 2 bits. It is an occupancy state machine with states EMPTY (0), ONE (1) and TWO (2). 3 is illegal.
  - `pending`, 1 bit: a read was issued last cycle and its data lands this cycle.
- `pop = m_valid & m_ready`.
- `push = pending`. Capture `fifo_dout` this cycle.
- `fifo_read = !rst & !fifo_empty & ((occ + pending - pop) < 2)`. Evaluate with 3-bit arithmetic; the result is never negative.
  - This gives a combinational path from `m_ready` to `fifo_read`. The path is required for full throughput.
- `pending` next value = `fifo_read`.
- State transitions (occ next = occ + push - pop):
  - EMPTY: push → ONE; otherwise stay.
  - ONE: push & !pop → TWO; !push & pop → EMPTY; otherwise stay.
  - TWO: pop & !push → ONE; pop & push → TWO; no pop → TWO. Push without pop while in TWO is impossible by the credit rule; flag it with an assertion.
- Data movement:
  - On pop, `buf0 <= buf1`.
  - A push writes slot `occ - pop`. That slot is `buf0` when EMPTY, or ONE with pop; it is `buf1` otherwise.
- Outputs: `m_valid = (occ != 0)`, `m_data = buf0`.
- Ordering: words are delivered in FIFO order, with no duplication and no drop.

## Timing
- Reset values:
  - `occ` = 0, `pending` = 0, `buf0` = `buf1` = 0.
  - `m_valid` = 0, `m_data` = 0, `fifo_read` = 0, `word_cnt` = 0.
- Latency:
  - A word first appears on `m_valid`/`m_data` 2 cycles after `fifo_read` is asserted into an empty block.
  - With `fifo_empty` low and the FIFO non-empty on the first cycle, `m_valid` rises 2 cycles after `rst` deasserts.
- Throughput: with `m_ready` held high and the FIFO non-empty, the block sustains 1 word/cycle (steady state: occ = ONE, pending = 1, pop = 1).
- Backpressure:
  - `m_ready` low → at most 2 words are buffered, then `fifo_read` stays low.
  - `m_valid` and `m_data` hold stable until accepted.
- `fifo_empty` rising while `pending` = 1: the in-flight word is still captured, and no further reads are issued.
- Simultaneous push and pop in ONE: the new word goes to `buf0`, and `occ` stays ONE.
- Reset mid-operation: buffered and in-flight words are discarded. The FIFO read side must be reset on the same cycle, otherwise words are lost.

## Configuration
- `FIFO_READER_CNT_EN` defined:
  - `word_cnt` is present and increments by 1 on each pop.
  - It wraps from 0xFFFFFFFF to 0.
  - It resets to 0.
- `FIFO_READER_CNT_EN` undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Reset, then FIFO preloaded with 0x11, 0x22, 0x33, `m_ready` = 1 → `m_data` = 0x11, 0x22, 0x33 on consecutive cycles; first valid 2 cycles after reset release.
- `m_ready` = 0 with the FIFO holding 5 words → exactly 2 `fifo_read` pulses; `occ` = TWO; `m_data` held at word 0. Releasing `m_ready` → all 5 words in order with no gap.
- `m_ready` toggling 1/0 every cycle over 16 words → 16 handshakes, in-order data, `fifo_read` never asserted while `occ + pending - pop` ≥ 2.
- FIFO drains to empty mid-stream with `pending` = 1 → the last word is still delivered; `fifo_read` stays 0 while `fifo_empty` = 1; the stream resumes after a new write.
- `rst` pulsed for 1 cycle with `occ` = TWO and `pending` = 1 → the next cycle shows `m_valid` = 0, `fifo_read` = 0, and `word_cnt` = 0.
- With `FIFO_READER_CNT_EN`, preload `word_cnt` near wrap (force to 0xFFFFFFFE), then 3 handshakes → `word_cnt` = 1.
